// File: rtl/ram_burst_if.sv
// Request / write-data / read-response handshake bundle for ram_burst_ctrl.
// The RAM-side bus stays on plain ports because it carries the tri-state data line.
interface ram_burst_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic                  wd_valid;
  logic                  wd_ready;
  logic [DATA_WIDTH-1:0] wd_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_last;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_addr, req_len, wd_valid, wd_data,
    input  req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, busy
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, wd_valid, wd_data,
    output req_ready, wd_ready, rsp_valid, rsp_data, rsp_last, busy
  );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a single-port sync RAM: sequences one RAM beat per cycle
// for read/write bursts and returns read beats on a non-backpressured stream.
module ram_burst_ctrl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_burst_if.slave            bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_oe_q, mem_oe_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_last_q, rsp_last_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    mem_cs_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_oe_d   = 1'b0;
    // Read beats are captured from whatever the RAM drives during the cycle cs/oe are up.
    rsp_valid_d = mem_cs_q & mem_oe_q & ~mem_we_q;
    rsp_data_d  = mem_data;
    rsp_last_d  = (state_q == RD) && (cnt_q == '0);

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d = bus.req_len;
          if (bus.req_we) begin
            state_d = WR;
            cur_d   = bus.req_addr;
          end else begin
            state_d    = RD;
            mem_cs_d   = 1'b1;
            mem_oe_d   = 1'b1;
            mem_addr_d = bus.req_addr;
          end
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          mem_cs_d   = 1'b1;
          mem_oe_d   = 1'b1;
          mem_addr_d = mem_addr_q + 1'b1;
          cnt_d      = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        // No beat offered -> the next cycle is a bubble with cs low.
        if (bus.wd_valid) begin
          mem_cs_d   = 1'b1;
          mem_we_d   = 1'b1;
          mem_addr_d = cur_q;
          wdata_d    = bus.wd_data;
          cur_d      = cur_q + 1'b1;
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cur_q       <= '0;
      mem_addr_q  <= '0;
      wdata_q     <= '0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_q       <= cur_d;
      mem_addr_q  <= mem_addr_d;
      wdata_q     <= wdata_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_cs   = mem_cs_q;
  assign mem_we   = mem_we_q;
  assign mem_oe   = mem_oe_q;
  // Only write beats put data on the shared bus; the RAM owns it otherwise.
  assign mem_data = (mem_cs_q & mem_we_q) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign bus.req_ready = (state_q == IDLE);
  assign bus.wd_ready  = (state_q == WR);
  assign bus.busy      = (state_q != IDLE) || mem_cs_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: behavioural RAM on the bus plus an
// address->data reference map updated from accepted write beats.
module tb_ram_burst_ctrl;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;
  logic          mem_cs, mem_we, mem_oe;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] model [int];
  logic [DW-1:0] ram [0:(1<<AW)-1];

  ram_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ram_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe)
  );

  always #5 clk = ~clk;

  // RAM: combinational read while selected for output, write committed at the edge.
  assign mem_data = (mem_cs && mem_oe && !mem_we) ? ram[mem_addr] : {DW{1'bz}};
  always @(posedge clk) if (mem_cs && mem_we) ram[mem_addr] <= mem_data;

  // Both sides can never own the data bus in the same cycle.
  always @(negedge clk) if (rst_n) begin
    checks++;
    if (mem_we && mem_oe) begin
      errors++;
      $display("FAIL bus_contention we=%0b oe=%0b want not both", mem_we, mem_oe);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [LW-1:0] l);
    int n = 0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_len = l;
    while (!bus.req_ready && n < 50) begin tick(); n++; end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_accept_timeout ready=%0b want 1", bus.req_ready);
    end
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = AW'($urandom);
    bus.req_len   = LW'($urandom);
    bus.req_we    = 1'($urandom);
  endtask

  task automatic write_burst(input logic [AW-1:0] a, input logic [LW-1:0] l,
                             input logic [DW-1:0] d[$], input int gaps[$]);
    logic [AW-1:0] ad;
    do_req(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      // Stray requests during the burst must be ignored; dropped before the final beat.
      bus.req_valid = (i != int'(l));
      if (gaps[i] > 0) begin
        bus.wd_valid = 1'b0;
        repeat (gaps[i]) begin
          tick();
          checks++;
          if (mem_cs !== 1'b0 || bus.wd_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_bubble cs=%0b wd_ready=%0b want cs=0 wd_ready=1", mem_cs, bus.wd_ready);
          end
        end
      end
      bus.wd_valid = 1'b1;
      bus.wd_data  = d[i];
      checks++;
      if (bus.wd_ready !== 1'b1) begin
        errors++;
        $display("FAIL wr_ready beat=%0d got=%0b want 1", i, bus.wd_ready);
      end
      tick();
      ad = a + AW'(i);
      checks++;
      if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_oe !== 1'b0 || mem_addr !== ad || mem_data !== d[i]) begin
        errors++;
        $display("FAIL wr_beat beat=%0d cs/we/oe=%0b%0b%0b addr=%h data=%h want 110 addr=%h data=%h",
                 i, mem_cs, mem_we, mem_oe, mem_addr, mem_data, ad, d[i]);
      end
      model[int'(ad)] = d[i];
    end
    bus.req_valid = 1'b0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = DW'($urandom);
  endtask

  task automatic read_burst(input logic [AW-1:0] a, input logic [LW-1:0] l);
    logic [AW-1:0] ad;
    logic [DW-1:0] exp;
    bus.wd_valid = 1'($urandom);
    bus.wd_data  = DW'($urandom);
    do_req(1'b0, a, l);
    checks++;
    if (mem_cs !== 1'b1 || mem_oe !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a || bus.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_issue cs/oe/we=%0b%0b%0b addr=%h rsp_valid=%0b want 110 addr=%h rsp_valid=0",
               mem_cs, mem_oe, mem_we, mem_addr, bus.rsp_valid, a);
    end
    // rsp_valid rises at the 2nd edge counting the accept edge, then one beat per cycle.
    for (int k = 0; k <= int'(l); k++) begin
      tick();
      ad  = a + AW'(k);
      exp = model[int'(ad)];
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp || bus.rsp_last !== (k == int'(l))) begin
        errors++;
        $display("FAIL rd_beat beat=%0d valid=%0b data=%h last=%0b want 1 data=%h last=%0b",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_last, exp, (k == int'(l)));
      end
    end
    tick();
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || mem_cs !== 1'b0) begin
      errors++;
      $display("FAIL rd_end valid=%0b busy=%0b cs=%0b want 0 0 0", bus.rsp_valid, bus.busy, mem_cs);
    end
    bus.wd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (mem_cs !== 0 || mem_we !== 0 || mem_oe !== 0 || mem_addr !== '0 || bus.rsp_valid !== 0 ||
        bus.rsp_data !== '0 || bus.rsp_last !== 0 || bus.busy !== 0 || bus.req_ready !== 1 || bus.wd_ready !== 0) begin
      errors++;
      $display("FAIL reset_state cs=%0b we=%0b oe=%0b addr=%h rv=%0b rd=%h rl=%0b busy=%0b rr=%0b wr=%0b want all 0 except req_ready=1",
               mem_cs, mem_we, mem_oe, mem_addr, bus.rsp_valid, bus.rsp_data, bus.rsp_last, bus.busy, bus.req_ready, bus.wd_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    write_burst(16'h0010, 4'd0, '{8'hA5}, '{0});
    tick();
    read_burst(16'h0010, 4'd0);
  endtask

  task automatic test_burst_gaps();
    write_burst(16'h0100, 4'd3, '{8'h11, 8'h22, 8'h33, 8'h44}, '{0, 2, 0, 0});
    tick();
    read_burst(16'h0100, 4'd3);
  endtask

  task automatic test_wrap();
    write_burst(16'hFFFF, 4'd2, '{8'h01, 8'h02, 8'h03}, '{0, 0, 0});
    tick();
    read_burst(16'hFFFF, 4'd2);
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d;
    d = DW'($urandom);
    if (d == model[16'h0010]) d = ~d;
    write_burst(16'h0010, 4'd0, '{d}, '{1});
    checks++;
    if (bus.req_ready !== 1'b1 || mem_cs !== 1'b1 || mem_we !== 1'b1) begin
      errors++;
      $display("FAIL b2b_final_cycle ready=%0b cs=%0b we=%0b want 1 1 1", bus.req_ready, mem_cs, mem_we);
    end
    read_burst(16'h0010, 4'd0);
  endtask

  task automatic test_max_len();
    logic [DW-1:0] d[$];
    int g[$];
    logic [AW-1:0] a;
    a = AW'($urandom);
    for (int i = 0; i < 16; i++) begin d.push_back(DW'($urandom)); g.push_back(0); end
    write_burst(a, 4'd15, d, g);
    tick();
    read_burst(a, 4'd15);
  endtask

  task automatic test_reset_mid_read();
    do_req(1'b0, 16'h0100, 4'd7);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_cs !== 0 || mem_oe !== 0 || mem_we !== 0 || bus.rsp_valid !== 0 || bus.rsp_last !== 0 || bus.busy !== 0) begin
      errors++;
      $display("FAIL reset_mid_read cs=%0b oe=%0b we=%0b rv=%0b rl=%0b busy=%0b want all 0",
               mem_cs, mem_oe, mem_we, bus.rsp_valid, bus.rsp_last, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();
    read_burst(16'h0101, 4'd2);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [AW-1:0] a;
      logic [LW-1:0] l;
      logic [DW-1:0] d[$];
      int g[$];
      a = AW'($urandom);
      l = LW'($urandom);
      for (int i = 0; i <= int'(l); i++) begin
        d.push_back(DW'($urandom));
        g.push_back(int'($urandom_range(0, 2)));
      end
      write_burst(a, l, d, g);
      if ($urandom_range(0, 1) == 1) tick();
      read_burst(a, LW'($urandom_range(0, int'(l))));
    end
  endtask

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = '0; bus.req_len = '0;
    bus.wd_valid = 0; bus.wd_data = '0;
    test_reset();
    test_single();
    test_burst_gaps();
    test_wrap();
    test_back_to_back();
    test_max_len();
    test_reset_mid_read();
    test_random();
    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached=1 want 0");
    $fatal(1, "timeout");
  end
endmodule
